// File: rtl/audio_adc_conditioner.sv
// audio_adc_conditioner: block-average decimation, DC removal and saturating 16-bit scaling of 12-bit ADC words; define CLIP_HOLD_EN for a held clip flag
module audio_adc_conditioner #(
  parameter int DECIM_LOG2     = 2,
  parameter int DC_SHIFT       = 10,
  parameter int GAIN_SHIFT     = 0,
  parameter int CLIP_HOLD_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mute,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  output logic [15:0] sample_out,
  output logic        sample_strobe,
  output logic        clip,
  output logic        overrun
);
  localparam int AW = 12 + DECIM_LOG2;
  localparam int DW = 14 + DC_SHIFT;
  localparam int ZW = 18 + GAIN_SHIFT;
  typedef enum logic [1:0] {IDLE, DC, SCALE, OUT} state_t;
  state_t                 r_state;
  logic                   r_valid_q;
  logic [AW-1:0]          r_acc;
  logic [DECIM_LOG2-1:0]  r_count;
  logic [11:0]            r_avg;
  logic signed [DW-1:0]   r_dc_acc;
  logic [13:0]            r_y;
  logic [15:0]            r_z;
  logic                   r_sat;
`ifdef CLIP_HOLD_EN
  localparam logic [CLIP_HOLD_LOG2:0] HOLD_LAST = (CLIP_HOLD_LOG2+1)'((1 << CLIP_HOLD_LOG2) - 1);
  logic [CLIP_HOLD_LOG2:0] r_hold;
`endif
  logic                   w_edge;
  logic                   w_wrap;
  logic [AW-1:0]          w_sum;
  logic signed [DW-1:0]   w_x;
  logic signed [DW-1:0]   w_dc_int;
  logic signed [DW-1:0]   w_step;
  logic [ZW-1:0]          w_z;
  logic                   w_ovf;
  // offset-binary to two's complement is just an MSB flip
  always_comb begin
    w_edge   = adc_valid & ~r_valid_q & enable;
    w_sum    = r_acc + AW'(adc_data);
    w_wrap   = &r_count;
    w_x      = DW'($signed({~r_avg[11], r_avg[10:0]}));
    w_dc_int = r_dc_acc >>> DC_SHIFT;
    w_step   = w_x - w_dc_int;
    w_z      = {{(4+GAIN_SHIFT){r_y[13]}}, r_y} << (4 + GAIN_SHIFT);
    w_ovf    = ~(&w_z[ZW-1:15] | ~|w_z[ZW-1:15]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_valid_q     <= 1'b0;
      r_acc         <= '0;
      r_count       <= '0;
      r_avg         <= '0;
      r_dc_acc      <= '0;
      r_y           <= '0;
      r_z           <= '0;
      r_sat         <= 1'b0;
      sample_out    <= '0;
      sample_strobe <= 1'b0;
      clip          <= 1'b0;
      overrun       <= 1'b0;
`ifdef CLIP_HOLD_EN
      r_hold        <= '0;
`endif
    end else if (!enable) begin
      r_state       <= IDLE;
      r_valid_q     <= 1'b0;
      r_acc         <= '0;
      r_count       <= '0;
      sample_strobe <= 1'b0;
`ifndef CLIP_HOLD_EN
      clip          <= 1'b0;
`endif
    end else begin
      r_valid_q     <= adc_valid;
      sample_strobe <= 1'b0;
`ifndef CLIP_HOLD_EN
      clip          <= 1'b0;
`endif
      if (w_edge && r_state != IDLE) overrun <= 1'b1;
      case (r_state)
        IDLE: if (w_edge) begin
          r_count <= r_count + 1'b1;
          r_acc   <= w_wrap ? '0 : w_sum;
          if (w_wrap) begin
            r_avg   <= w_sum[AW-1:DECIM_LOG2];
            r_state <= DC;
          end
        end
        DC: begin
          r_y      <= w_step[13:0];
          r_dc_acc <= r_dc_acc + w_step;
          r_state  <= SCALE;
        end
        SCALE: begin
          r_z     <= w_ovf ? (w_z[ZW-1] ? 16'h8000 : 16'h7fff) : w_z[15:0];
          r_sat   <= w_ovf;
          r_state <= OUT;
        end
        OUT: begin
          sample_out    <= mute ? '0 : r_z;
          sample_strobe <= 1'b1;
          r_state       <= IDLE;
`ifdef CLIP_HOLD_EN
          if (r_sat) begin
            clip   <= 1'b1;
            r_hold <= '0;
          end else if (clip) begin
            clip   <= r_hold != HOLD_LAST;
            r_hold <= r_hold + 1'b1;
          end
`else
          clip          <= r_sat;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_audio_adc_conditioner.sv
// tb_audio_adc_conditioner: directed vectors against default and GAIN_SHIFT=2 instances sharing one stimulus
module tb_audio_adc_conditioner;
  logic clk = 1'b0;
  logic reset, enable, mute, adc_valid;
  logic [11:0] adc_data;
  logic signed [15:0] so_a, so_b;
  logic stb_a, stb_b, clip_a, clip_b, ovr_a, ovr_b;
  int n_tests = 0, n_fail = 0, n_stb = 0, base = 0;
`ifdef CLIP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) if (stb_a) n_stb <= n_stb + 1;

  audio_adc_conditioner u_dut (
    .clk(clk), .reset(reset), .enable(enable), .mute(mute),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .sample_out(so_a), .sample_strobe(stb_a), .clip(clip_a), .overrun(ovr_a)
  );
  audio_adc_conditioner #(.GAIN_SHIFT(2)) u_g2 (
    .clk(clk), .reset(reset), .enable(enable), .mute(mute),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .sample_out(so_b), .sample_strobe(stb_b), .clip(clip_b), .overrun(ovr_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [11:0] d);
    adc_data = d;
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_strobe(input string tag, input int lat);
    int n = 0;
    while (!stb_a && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_stb_b"}, int'(stb_b), int'(stb_a));
  endtask

  task automatic blk(input string tag, input logic [11:0] d, input int ea, input int eb);
    repeat (4) send(d);
    wait_strobe(tag, 2);
    check({tag, "_a"}, so_a, ea);
    check({tag, "_b"}, so_b, eb);
  endtask

  initial begin
    enable = 1'b1; mute = 1'b0; adc_valid = 1'b0; adc_data = '0;
    do_reset();
    check("rst_out", so_a, 0);
    check("rst_stb", int'(stb_a), 0);
    check("rst_clip", int'(clip_a), 0);
    check("rst_ovr", int'(ovr_a), 0);

    blk("t1", 12'd2048, 0, 0);
    check("t1_clip", int'(clip_a), 0);
    @(posedge clk); #1;
    check("t1_pulse", int'(stb_a), 0);

    do_reset();
    blk("t2a", 12'd3072, 16384, 32767);
    check("t2a_clip_a", int'(clip_a), 0);
    check("t2a_clip_b", int'(clip_b), 1);
    blk("t2b", 12'd3072, 16368, 32767);
    blk("t2c", 12'd3072, 16368, 32767);
    blk("t2d", 12'd3072, 16352, 32767);

    do_reset();
    blk("t3p", 12'd4095, 32752, 32767);
    check("t3p_clip_a", int'(clip_a), 0);
    check("t3p_clip_b", int'(clip_b), 1);
    do_reset();
    blk("t3n", 12'd0, -32768, -32768);
    check("t3n_clip_a", int'(clip_a), 0);
    check("t3n_clip_b", int'(clip_b), 1);
    @(posedge clk); #1;
    check("t3n_clip_after", int'(clip_b), int'(HOLD));
    for (int i = 0; i < 16; i++) begin
      blk("t3h", 12'd2048, 32, 128);
      check("t3h_clip_b", int'(clip_b), int'(HOLD && i < 15));
    end

    do_reset();
    base = n_stb;
    adc_data = 12'd3072; adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_data = 12'd0;
    repeat (9) @(posedge clk);
    #1 adc_valid = 1'b0;
    @(posedge clk); #1;
    repeat (2) send(12'd3072);
    repeat (4) @(posedge clk);
    #1 check("t4_nostb", n_stb - base, 0);
    send(12'd3072);
    wait_strobe("t4", 2);
    check("t4_a", so_a, 16384);

    do_reset();
    base = n_stb;
    repeat (3) send(12'd2048);
    adc_data = 12'd2048; adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    @(posedge clk); #1;
    adc_data = 12'd4095; adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    check("t5_ovr", int'(ovr_a), 1);
    wait_strobe("t5", 1);
    check("t5_a", so_a, 0);
    repeat (3) send(12'd3072);
    repeat (4) @(posedge clk);
    #1 check("t5_one_stb", n_stb - base, 1);
    send(12'd3072);
    wait_strobe("t5b", 2);
    check("t5b_a", so_a, 16384);
    check("t5_ovr_sticky", int'(ovr_a), 1);
    check("t5_ovr_b", int'(ovr_b), 1);
    do_reset();
    check("t5_ovr_clr", int'(ovr_a), 0);

    repeat (2) send(12'd3072);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    base = n_stb;
    repeat (3) send(12'd2048);
    repeat (4) @(posedge clk);
    #1 check("t6_nostb", n_stb - base, 0);
    send(12'd2048);
    wait_strobe("t6", 2);
    check("t6_a", so_a, 0);
    mute = 1'b1;
    blk("t6m", 12'd3072, 0, 0);
    check("t6m_clip_a", int'(clip_a), 0);
    mute = 1'b0;
    blk("t6u", 12'd3072, 16368, 32767);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_adc_conditioner.md
Name: audio_adc_conditioner

Overview:
- Sits directly downstream of the SPI_MCP3202 ADC capture core and feeds the HDMI audio sample path in place of the raw shift-and-LPF chain.
- Accepts 12-bit unsigned ADC words on a valid strobe and decimates by block-averaging.
- Removes DC offset with a first-order tracking filter, then scales to signed 16-bit with saturation.
- Emits one sample plus a one-cycle strobe per block. Runs entirely in the ADC clock domain (clk_135_w at top level).

Parameters:
- DECIM_LOG2, 2: block size is 2^DECIM_LOG2 accepted ADC samples averaged per output.
- DC_SHIFT, 10: DC tracker time constant; update weight is 2^-DC_SHIFT.
- GAIN_SHIFT, 0: extra left shift applied after the fixed 12-to-16-bit shift of 4.
- CLIP_HOLD_LOG2, 4: clip hold length in output samples; used only with CLIP_HOLD_EN.

Ports:
- clk  in  1  block clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high = process samples; low = flush the block in progress.
- mute  in  1  high = force sample_out to 0; strobes continue.
- adc_valid  in  1  ADC DATA_VALID level; may stay high for many cycles.
- adc_data  in  12  unsigned ADC word, sampled only on the accepting edge.
- sample_out  out  16  signed conditioned sample; held between strobes.
- sample_strobe  out  1  one-cycle pulse when sample_out updates.
- clip  out  1  saturation indicator (see Optional Feature).
- overrun  out  1  sticky: an ADC edge was dropped.

Behaviour:

Reset:
- Registers: sample_out=0, sample_strobe=0, clip=0, overrun=0, acc=0, count=0, dc_acc=0, valid_q=0.
- State = IDLE.

Edge accept:
- valid_q <= adc_valid every cycle.
- A sample is accepted at a clock edge where adc_valid=1, valid_q=0, enable=1 and state=IDLE.
- A level held high counts once.
- If adc_valid=1, valid_q=0, enable=1 and state is not IDLE, the sample is dropped and overrun <= 1. overrun clears only on reset.

IDLE:
- On accept: acc <= acc + adc_data (acc width 12+DECIM_LOG2, unsigned).
- count increments, with width DECIM_LOG2.
- When count wraps to 0, avg = (acc + adc_data) >> DECIM_LOG2, acc <= 0, state <= DC.

DC, 1 cycle:
- x = avg - 2048, 13-bit signed, range -2048..2047.
- dc_int = dc_acc >>> DC_SHIFT, using the old dc_acc.
- y = x - dc_int, 14-bit signed.
- dc_acc <= dc_acc + x - dc_int, signed, width 13+DC_SHIFT+1.
- state <= SCALE.

SCALE, 1 cycle:
- z = y <<< (4+GAIN_SHIFT), computed at full width.
- Saturate to -32768..32767; sat flag = saturation occurred.
- state <= OUT.

OUT, 1 cycle:
- sample_out <= mute ? 0 : saturated z.
- sample_strobe <= 1 for exactly this one cycle.
- state <= IDLE.

Latency:
- sample_strobe is high in the cycle after the third clock edge following the edge that accepted a block's final sample.

enable low:
- At the next edge: acc, count and valid_q clear, and state <= IDLE, aborting any pipeline in flight without a strobe.
- dc_acc, sample_out and overrun are retained.

mute:
- Affects sample_out only. The DC tracker keeps updating.

Optional Feature:
- Macro CLIP_HOLD_EN.
- Defined: clip goes to 1 at the OUT cycle of any saturated sample and stays 1 until 2^CLIP_HOLD_LOG2 further non-saturated strobes have occurred. A new saturation restarts the hold count.
- Undefined: clip is a one-cycle pulse coincident with sample_strobe when that sample saturated, otherwise 0. CLIP_HOLD_LOG2 is ignored.

Test Plan:
1. Defaults, 4 edges of adc_data=2048 -> one strobe, 3 cycles after the 4th accept edge, with sample_out=0, clip=0.
2. After reset, 4 edges of 3072 -> sample_out=16384. Next 4 edges of 3072 -> 16368 (dc_int=1). Repeated blocks -> output decays toward 0.
3. GAIN_SHIFT=2, after reset, 4 edges of 4095 -> sample_out=32767 with clip=1. Reset, then 4 edges of 0 -> -32768 with clip=1. With CLIP_HOLD_EN, clip then stays high for 16 further unsaturated strobes.
4. adc_valid held high 10 cycles, then 3 more pulses -> exactly one strobe, after the 4th pulse. No extra samples counted.
5. Produce an edge on the cycle state=DC -> sample dropped, overrun=1 until reset. The next block still needs 4 accepted edges.
6. Accept 2 samples, drop enable for 1 cycle, re-enable -> 4 more edges are needed before the strobe. With mute=1, the strobe still fires and sample_out=0.
